// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter: FSM state codes, mode-bit
// positions and the layout of the ALU flag vector.
// Latency: n/a (definitions only). Backpressure: n/a.
package shifter_pkg;

  // FSM state encoding (kept as plain constants for legacy tooling).
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bit positions inside the captured 3-bit mode register.
  localparam int MODE_W   = 3;
  localparam int MODE_LR  = 0;  // 1 = right, 0 = left
  localparam int MODE_LA  = 1;  // 1 = arithmetic
  localparam int MODE_ROT = 2;  // 1 = rotate, overrides LA

  // Positions in the shared ALU flag vector.
  localparam int FLAG_W = 4;
  localparam int FLAG_C = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 3;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic n,
                                                   input logic v, input logic z);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/shifter_step.sv
// One-bit shift/rotate step on a WIDTH-bit word.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: din/lr/la/rot in; dout = stepped word, out_bit = bit leaving the
// word, msb_changed = dout MSB differs from din MSB.
module shifter_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  logic             lr,
  input  logic             la,
  input  logic             rot,
  output logic [WIDTH-1:0] dout,
  output logic             out_bit,
  output logic             msb_changed
);

  logic fill;

  always_comb begin
    dout    = din;
    out_bit = 1'b0;
    fill    = 1'b0;
    if (lr) begin
      out_bit = din[0];
      // Rotate recirculates the outgoing bit; arithmetic replicates the sign.
      if (rot)     fill = din[0];
      else if (la) fill = din[WIDTH-1];
      else         fill = 1'b0;
      dout = {fill, din[WIDTH-1:1]};
    end else begin
      out_bit = din[WIDTH-1];
      // Left shifts never sign-fill; only rotate brings a bit back in.
      fill = rot ? din[WIDTH-1] : 1'b0;
      dout = {din[WIDTH-2:0], fill};
    end
    msb_changed = dout[WIDTH-1] ^ din[WIDTH-1];
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: logical/arithmetic/rotate, left/right, one bit per clock.
// Latency: done pulses AMT+1 cycles after the accepting edge (1 cycle for AMT=0).
// Backpressure: start is ignored while busy; accepted in IDLE or in the done cycle.
// Ports: clk, rst_n (async, active-low); start, A, AMT, LR, LA, ROT request in;
// busy, done, Y and registered C/N/V/Z flags out.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [AW-1:0]    AMT,
  input  logic             LR,
  input  logic             LA,
  input  logic             ROT,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             N,
  output logic             V,
  output logic             Z
);

  state_t              state_q;
  logic [WIDTH-1:0]    work_q;
  logic [AW-1:0]       cnt_q;
  logic [MODE_W-1:0]   mode_q;
  logic                vsticky_q;
  logic [WIDTH-1:0]    y_q;
  logic [FLAG_W-1:0]   flags_q;

  logic [WIDTH-1:0]    step_dout;
  logic                step_out;
  logic                step_msb_chg;
  logic                v_step;
  logic [AW:0]         amt_ext;
  logic [AW-1:0]       amt_sat;

  shifter_step #(.WIDTH(WIDTH)) u_step (
    .din         (work_q),
    .lr          (mode_q[MODE_LR]),
    .la          (mode_q[MODE_LA]),
    .rot         (mode_q[MODE_ROT]),
    .dout        (step_dout),
    .out_bit     (step_out),
    .msb_changed (step_msb_chg)
  );

  // Overflow only matters for arithmetic left shifts.
  assign v_step = mode_q[MODE_LA] & ~mode_q[MODE_ROT] & ~mode_q[MODE_LR] & step_msb_chg;

  // Counts beyond WIDTH-1 can only occur for non-power-of-two WIDTH.
  always_comb begin
    amt_ext = {1'b0, AMT};
    amt_sat = AMT;
    if (amt_ext >= (AW+1)'(WIDTH)) amt_sat = AW'(WIDTH-1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      vsticky_q <= 1'b0;
      y_q       <= '0;
      flags_q   <= pack_flags(1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      case (state_q)
        ST_SHIFT: begin
          work_q    <= step_dout;
          cnt_q     <= cnt_q - AW'(1);
          vsticky_q <= vsticky_q | v_step;
          // Last step: publish the stepped word directly so the results are
          // valid in the first DONE cycle.
          if (cnt_q == AW'(1)) begin
            state_q <= ST_DONE;
            y_q     <= step_dout;
            flags_q <= pack_flags(step_out, step_dout[WIDTH-1],
                                  vsticky_q | v_step, step_dout == '0);
          end
        end
        default: begin  // IDLE, DONE (and any illegal code recovers here)
          if (start) begin
            work_q    <= A;
            mode_q    <= {ROT, LA, LR};
            vsticky_q <= 1'b0;
            if (amt_sat == '0) begin
              state_q <= ST_DONE;
              cnt_q   <= '0;
              y_q     <= A;
              flags_q <= pack_flags(1'b0, A[WIDTH-1], 1'b0, A == '0);
            end else begin
              state_q <= ST_SHIFT;
              cnt_q   <= amt_sat;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign Y    = y_q;
  assign C    = flags_q[FLAG_C];
  assign N    = flags_q[FLAG_N];
  assign V    = flags_q[FLAG_V];
  assign Z    = flags_q[FLAG_Z];

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter (WIDTH=8): directed requests push expected
// results; a negedge monitor pops and compares whenever done is seen.
// Latency is checked as the cycle index at which done appears.
module tb_seq_shifter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [2:0] AMT;
  logic       LR, LA, ROT;
  logic       busy, done;
  logic [7:0] Y;
  logic       C, N, V, Z;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] y;
    logic       c, n, v, z;
    int         dcyc;
  } exp_t;

  exp_t exp_q[$];

  seq_shifter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .AMT   (AMT),
    .LR    (LR),
    .LA    (LA),
    .ROT   (ROT),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .C     (C),
    .N     (N),
    .V     (V),
    .Z     (Z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=Y%0h expected=no_done (t=%0t)", Y, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("Y", {24'b0, Y}, {24'b0, e.y});
        chk("C", {31'b0, C}, {31'b0, e.c});
        chk("N", {31'b0, N}, {31'b0, e.n});
        chk("V", {31'b0, V}, {31'b0, e.v});
        chk("Z", {31'b0, Z}, {31'b0, e.z});
        chk("done_cycle", cyc, e.dcyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [2:0] amt,
                       input logic lr, input logic la, input logic rot,
                       input logic [7:0] ey, input logic ec, input logic en,
                       input logic ev, input logic ez, input logic push);
    exp_t e;
    A = a; AMT = amt; LR = lr; LA = la; ROT = rot; start = 1'b1;
    e.y = ey; e.c = ec; e.n = en; e.v = ev; e.z = ez;
    e.dcyc = cyc + 1 + int'(amt);
    if (push) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_done actual=timeout expected=done_within_%0d", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; AMT = '0; LR = 1'b0; LA = 1'b0; ROT = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_Y", {24'b0, Y}, 0);
    chk("rst_C", {31'b0, C}, 0);
    chk("rst_N", {31'b0, N}, 0);
    chk("rst_V", {31'b0, V}, 0);
    chk("rst_Z", {31'b0, Z}, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic right: 1000_0001 >>> 3 = 1111_0000, last out bit 0.
    issue(8'h81, 3'd3, 1, 1, 0, 8'hF0, 0, 1, 0, 0, 1); wait_done(20); @(negedge clk);
    // Arithmetic left 0x40 by 1: MSB flips -> V.
    issue(8'h40, 3'd1, 0, 1, 0, 8'h80, 0, 1, 1, 0, 1); wait_done(20); @(negedge clk);
    // Same as logical left: no V.
    issue(8'h40, 3'd1, 0, 0, 0, 8'h80, 0, 1, 0, 0, 1); wait_done(20); @(negedge clk);
    // Rotate right 0x01 by 1.
    issue(8'h01, 3'd1, 1, 0, 1, 8'h80, 1, 1, 0, 0, 1); wait_done(20); @(negedge clk);
    // Logical right 0x01 by 1 -> zero.
    issue(8'h01, 3'd1, 1, 0, 0, 8'h00, 1, 0, 0, 1, 1); wait_done(20); @(negedge clk);
    // Arithmetic left 0x40 by 2: V stays sticky though final MSB is 0.
    issue(8'h40, 3'd2, 0, 1, 0, 8'h00, 1, 0, 1, 1, 1); wait_done(20); @(negedge clk);
    // Rotate left 0x81 by 1 with LA=1: rotate wins, no V.
    issue(8'h81, 3'd1, 0, 1, 1, 8'h03, 1, 0, 0, 0, 1); wait_done(20); @(negedge clk);

    // AMT=0 then back-to-back request in the done cycle.
    issue(8'h5A, 3'd0, 0, 1, 0, 8'h5A, 0, 0, 0, 0, 1); wait_done(20);
    issue(8'h03, 3'd2, 0, 0, 0, 8'h0C, 0, 0, 0, 0, 1);
    chk("b2b_busy", {31'b0, busy}, 1);
    wait_done(20); @(negedge clk);

    // Start during busy is ignored; Y holds the previous result meanwhile.
    issue(8'hFF, 3'd7, 0, 0, 0, 8'h80, 1, 1, 0, 0, 1);
    chk("mid_busy", {31'b0, busy}, 1);
    A = 8'h00; AMT = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'hAA;
    chk("mid_Y_hold", {24'b0, Y}, 32'h0C);
    wait_done(20); @(negedge clk);

    // Reset mid-shift: outputs return to reset values at once, no done later.
    issue(8'hFF, 3'd7, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_Y", {24'b0, Y}, 0);
    chk("arst_C", {31'b0, C}, 0);
    chk("arst_N", {31'b0, N}, 0);
    chk("arst_Z", {31'b0, Z}, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Normal operation afterwards: 1100_0000 >> 7 = 0000_0001, last out 1.
    issue(8'hC0, 3'd7, 1, 0, 0, 8'h01, 1, 0, 0, 0, 1); wait_done(20);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
